// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the player sprite walk controller.
package sprite_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MOVE  = 2'd2
    } walk_state_t;

    localparam int SPR_W  = 20;
    localparam int SPR_H  = 20;
    localparam int GRID_W = 32;
    localparam int GRID_H = 24;

endpackage

// File: rtl/sprite_offset_calc.sv
// Beam-to-sprite offset: signed dx/dy against the sprite origin, box test,
// and a register stage so the renderer sees one pixel-clock latency.
module sprite_offset_calc #(
    parameter int SPR_W = 20,
    parameter int SPR_H = 20
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [9:0]  draw_x_i,
    input  logic [9:0]  draw_y_i,
    input  logic [10:0] pos_x_i,
    input  logic [10:0] pos_y_i,
    output logic [19:0] sprite_dx_o,
    output logic [19:0] sprite_dy_o,
    output logic        sprite_on_o
);

    logic [10:0] dx, dy;
    logic        on_d;
    logic [19:0] sdx_d, sdy_d;
    logic [19:0] sdx_q, sdy_q;
    logic        on_q;

    // Two's-complement difference; bit 10 is the sign.
    assign dx = {1'b0, draw_x_i} - pos_x_i;
    assign dy = {1'b0, draw_y_i} - pos_y_i;

    always_comb begin
        on_d  = !dx[10] && (dx < 11'(SPR_W)) && !dy[10] && (dy < 11'(SPR_H));
        sdx_d = 20'd0;
        sdy_d = 20'd0;
        if (on_d) begin
            sdx_d = {9'd0, dx};
            sdy_d = {9'd0, dy};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            on_q  <= 1'b0;
            sdx_q <= 20'd0;
            sdy_q <= 20'd0;
        end else begin
            on_q  <= on_d;
            sdx_q <= sdx_d;
            sdy_q <= sdy_d;
        end
    end

    assign sprite_on_o = on_q;
    assign sprite_dx_o = sdx_q;
    assign sprite_dy_o = sdy_q;

endmodule

// File: rtl/sprite_walk_ctrl.sv
// Player sprite controller: command accept (cmd_valid & cmd_ready), wall lookup
// (wall_req held until wall_ack), then a one-pixel-per-frame walk to the next tile.
module sprite_walk_ctrl #(
    parameter int SPR_W    = sprite_pkg::SPR_W,
    parameter int SPR_H    = sprite_pkg::SPR_H,
    parameter int GRID_W   = sprite_pkg::GRID_W,
    parameter int GRID_H   = sprite_pkg::GRID_H,
    parameter int ANIM_DIV = 5,
    parameter int START_TX = 1,
    parameter int START_TY = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_dir,
    output logic        cmd_ready,
    output logic        wall_req,
    output logic [4:0]  wall_tx,
    output logic [4:0]  wall_ty,
    input  logic        wall_ack,
    input  logic        wall_hit,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [19:0] Sprite_dx,
    output logic [19:0] Sprite_dy,
    output logic        sprite_on,
    output logic [1:0]  anim_frame,
    output logic [1:0]  dir_out,
    output logic [4:0]  tile_x,
    output logic [4:0]  tile_y,
    output logic        busy
);
    import sprite_pkg::*;

    localparam int STEP_W = $clog2(SPR_W + 1);
    localparam int DIV_W  = $clog2(ANIM_DIV + 1);

    walk_state_t       state_q, state_d;
    dir_t              dir_q, dir_d;
    logic [4:0]        tile_x_q, tile_x_d, tile_y_q, tile_y_d;
    logic [4:0]        tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        anim_q, anim_d;

    logic signed [6:0] nx, ny;
    logic              in_grid;

    always_comb begin
        nx = $signed({2'b00, tile_x_q});
        ny = $signed({2'b00, tile_y_q});
        case (dir_t'(cmd_dir))
            UP:      ny = ny - 7'sd1;
            DOWN:    ny = ny + 7'sd1;
            LEFT:    nx = nx - 7'sd1;
            default: nx = nx + 7'sd1;
        endcase
        in_grid = (nx >= 7'sd0) && (nx < $signed(7'(GRID_W))) &&
                  (ny >= 7'sd0) && (ny < $signed(7'(GRID_H)));
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        tile_x_d = tile_x_q;
        tile_y_d = tile_y_q;
        tgt_x_d  = tgt_x_q;
        tgt_y_d  = tgt_y_q;
        step_d   = step_q;
        div_d    = div_q;
        anim_d   = anim_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d = dir_t'(cmd_dir);
                    // Off-grid targets are consumed silently with no lookup.
                    if (in_grid) begin
                        tgt_x_d = nx[4:0];
                        tgt_y_d = ny[4:0];
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (wall_ack) begin
                    step_d = '0;
                    div_d  = '0;
                    anim_d = 2'd0;
                    state_d = wall_hit ? IDLE : MOVE;
                end
            end
            MOVE: begin
                if (frame_start) begin
                    if (step_q == STEP_W'(SPR_W - 1)) begin
                        tile_x_d = tgt_x_q;
                        tile_y_d = tgt_y_q;
                        step_d   = '0;
                        div_d    = '0;
                        anim_d   = 2'd0;
                        state_d  = IDLE;
                    end else begin
                        step_d = step_q + 1'b1;
                        if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                            div_d  = '0;
                            anim_d = anim_q + 2'd1;
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dir_q    <= DOWN;
            tile_x_q <= 5'(START_TX);
            tile_y_q <= 5'(START_TY);
            tgt_x_q  <= 5'd0;
            tgt_y_q  <= 5'd0;
            step_q   <= '0;
            div_q    <= '0;
            anim_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            tile_x_q <= tile_x_d;
            tile_y_q <= tile_y_d;
            tgt_x_q  <= tgt_x_d;
            tgt_y_q  <= tgt_y_d;
            step_q   <= step_d;
            div_q    <= div_d;
            anim_q   <= anim_d;
        end
    end

    // Sprite origin in pixels; only the moving axis is offset by step.
    logic [10:0] base_x, base_y, step_ext, pos_x, pos_y;
    assign base_x   = 11'(tile_x_q) * 11'(SPR_W);
    assign base_y   = 11'(tile_y_q) * 11'(SPR_H);
    assign step_ext = 11'(step_q);

    always_comb begin
        pos_x = base_x;
        pos_y = base_y;
        case (dir_q)
            UP:      pos_y = base_y - step_ext;
            DOWN:    pos_y = base_y + step_ext;
            LEFT:    pos_x = base_x - step_ext;
            default: pos_x = base_x + step_ext;
        endcase
    end

    sprite_offset_calc #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_offset (
        .clk_i       (vga_clk),
        .reset_n_i   (reset_n),
        .draw_x_i    (DrawX),
        .draw_y_i    (DrawY),
        .pos_x_i     (pos_x),
        .pos_y_i     (pos_y),
        .sprite_dx_o (Sprite_dx),
        .sprite_dy_o (Sprite_dy),
        .sprite_on_o (sprite_on)
    );

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign wall_req   = (state_q == CHECK);
    assign wall_tx    = tgt_x_q;
    assign wall_ty    = tgt_y_q;
    assign anim_frame = anim_q;
    assign dir_out    = dir_q;
    assign tile_x     = tile_x_q;
    assign tile_y     = tile_y_q;

endmodule
